// File: rtl/sgpr_rfa_pkg.sv
// Shared types and constants for the SGPR read-port arbiter (FU ordering, vector/id types).
// Latency: n/a (declarations only).
// Backpressure: n/a; starvation sizing is consumed only when SGPR_RFA_STARVE_EN is defined.
package sgpr_rfa_pkg;

    localparam int NUM_FU       = 16;
    localparam int PTR_W        = 4;
    localparam int STARVE_LIMIT = 8;
    localparam int STARVE_W     = $clog2(STARVE_LIMIT + 1);

    typedef logic [NUM_FU-1:0]   fu_vec_t;
    typedef logic [PTR_W-1:0]    fu_id_t;
    typedef logic [STARVE_W-1:0] starve_cnt_t;

    // Bit positions in fu_req / rfa_select_fu; indices 10..15 are reserved.
    localparam fu_id_t FU_SIMD0 = 4'd0;
    localparam fu_id_t FU_SIMD1 = 4'd1;
    localparam fu_id_t FU_SIMD2 = 4'd2;
    localparam fu_id_t FU_SIMD3 = 4'd3;
    localparam fu_id_t FU_SIMF0 = 4'd4;
    localparam fu_id_t FU_SIMF1 = 4'd5;
    localparam fu_id_t FU_SIMF2 = 4'd6;
    localparam fu_id_t FU_SIMF3 = 4'd7;
    localparam fu_id_t FU_LSU   = 4'd8;
    localparam fu_id_t FU_SALU  = 4'd9;

endpackage

// File: rtl/sgpr_rfa_arb_if.sv
// Request/grant bundle between the functional units and the SGPR read-port arbiter.
// Latency: wires only.
// Backpressure: port_stall travels with the requests; grants come back registered.
interface sgpr_rfa_arb_if;
    import sgpr_rfa_pkg::*;

    fu_vec_t fu_req;
    logic    port_stall;
    fu_vec_t rfa_select_fu;
    logic    grant_valid;
    fu_id_t  grant_id;

    // Requester side: raises requests and the stall, observes grants.
    modport master (
        output fu_req, port_stall,
        input  rfa_select_fu, grant_valid, grant_id
    );

    // Arbiter side.
    modport slave (
        input  fu_req, port_stall,
        output rfa_select_fu, grant_valid, grant_id
    );

endinterface

// File: rtl/sgpr_rfa_rr_pick.sv
// Rotate-priority encoder: first set bit of elig scanning upward from ptr, wrapping 15 -> 0.
// Latency: purely combinational.
// Backpressure: none; win_vld low when elig is empty.
module sgpr_rfa_rr_pick
    import sgpr_rfa_pkg::*;
(
    input  fu_vec_t elig,
    input  fu_id_t  ptr,
    output fu_vec_t win_oh,
    output fu_id_t  win_id,
    output logic    win_vld
);

    fu_id_t cand;

    // Walk the 16 positions starting at ptr; 4-bit addition gives the wrap for free.
    always_comb begin
        win_oh  = '0;
        win_id  = '0;
        win_vld = 1'b0;
        cand    = '0;
        for (int k = 0; k < NUM_FU; k++) begin
            cand = ptr + fu_id_t'(k);
            if (!win_vld && elig[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
        win_oh[win_id] = win_vld;
    end

endmodule

// File: rtl/sgpr_rfa_arb.sv
// SGPR read-port arbiter: round-robin one-hot grant over 16 FUs (optional starvation escalation, macro SGPR_RFA_STARVE_EN).
// Latency: request sampled at edge N is granted in the cycle after edge N; grants are registered.
// Backpressure: port_stall suppresses the next grant and freezes the pointer (and wait counters).
module sgpr_rfa_arb
    import sgpr_rfa_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    sgpr_rfa_arb_if.slave  rfa
);

    fu_vec_t sel_q, sel_d;
    fu_id_t  ptr_q, ptr_d;
    fu_id_t  gid_q, gid_d;
    logic    gvld_q, gvld_d;

    fu_vec_t elig;
    fu_vec_t rr_oh;
    fu_id_t  rr_id;
    logic    rr_vld;
    fu_vec_t win_oh;
    fu_id_t  win_id;
    logic    win_vld;

    // The FU holding the port this cycle sits out the next arbitration.
    assign elig = rfa.fu_req & ~sel_q;

    sgpr_rfa_rr_pick u_pick (
        .elig    (elig),
        .ptr     (ptr_q),
        .win_oh  (rr_oh),
        .win_id  (rr_id),
        .win_vld (rr_vld)
    );

`ifdef SGPR_RFA_STARVE_EN
    starve_cnt_t cnt_q [NUM_FU];
    starve_cnt_t cnt_d [NUM_FU];

    // Lowest-index eligible FU whose wait count hit the limit overrides round-robin.
    always_comb begin
        win_oh  = rr_oh;
        win_id  = rr_id;
        win_vld = rr_vld;
        for (int i = NUM_FU - 1; i >= 0; i--) begin
            if (elig[i] && (cnt_q[i] >= starve_cnt_t'(STARVE_LIMIT))) begin
                win_oh    = '0;
                win_oh[i] = 1'b1;
                win_id    = fu_id_t'(i);
                win_vld   = 1'b1;
            end
        end
    end

    // Wait counters: frozen under stall, cleared on grant or idle, else count up and saturate.
    always_comb begin
        cnt_d = cnt_q;
        if (!rfa.port_stall) begin
            for (int i = 0; i < NUM_FU; i++) begin
                if (!rfa.fu_req[i] || (win_vld && win_oh[i])) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] < starve_cnt_t'(STARVE_LIMIT)) begin
                    cnt_d[i] = cnt_q[i] + starve_cnt_t'(1);
                end
            end
        end
    end

    // Wait counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_FU; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign win_oh  = rr_oh;
    assign win_id  = rr_id;
    assign win_vld = rr_vld;
`endif

    // Next grant and pointer; a stall or empty eligible set yields no grant and a held pointer.
    always_comb begin
        sel_d  = '0;
        gid_d  = '0;
        gvld_d = 1'b0;
        ptr_d  = ptr_q;
        if (!rfa.port_stall && win_vld) begin
            sel_d  = win_oh;
            gid_d  = win_id;
            gvld_d = 1'b1;
            ptr_d  = win_id + fu_id_t'(1);
        end
    end

    // Grant and pointer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q  <= '0;
            ptr_q  <= '0;
            gid_q  <= '0;
            gvld_q <= 1'b0;
        end else begin
            sel_q  <= sel_d;
            ptr_q  <= ptr_d;
            gid_q  <= gid_d;
            gvld_q <= gvld_d;
        end
    end

    assign rfa.rfa_select_fu = sel_q;
    assign rfa.grant_valid   = gvld_q;
    assign rfa.grant_id      = gid_q;

endmodule

// File: tb/tb_sgpr_rfa_arb.sv
// Bench for sgpr_rfa_arb: directed vectors with literal expectations plus a per-cycle reference model.
// Latency: model predicts the grant visible one cycle after inputs are sampled.
// Backpressure: exercises port_stall and asynchronous reset mid-stream.
module tb_sgpr_rfa_arb;
    import sgpr_rfa_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n = 1'b0;
    fu_vec_t fu_req = '0;
    logic    port_stall = 1'b0;

    int n_chk  = 0;
    int n_pass = 0;

    sgpr_rfa_arb_if rfa_if ();
    assign rfa_if.fu_req     = fu_req;
    assign rfa_if.port_stall = port_stall;

    sgpr_rfa_arb dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rfa   (rfa_if)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_chk++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp_v, $time);
    endtask

    // ---------------- reference model ----------------
    // exp_gnt: FU holding the port in the current cycle, -1 for none.
    int exp_gnt = -1;
    int m_ptr   = 0;
    int m_cnt [16];

    function automatic int model_pick(input fu_vec_t req, input int held, input int ptr,
                                      input int cnt [16]);
        int w;
        w = -1;
`ifdef SGPR_RFA_STARVE_EN
        for (int i = 0; i < 16; i++)
            if (w < 0 && req[i] && i != held && cnt[i] >= STARVE_LIMIT) w = i;
`endif
        for (int k = 0; k < 16; k++) begin
            int i;
            i = (ptr + k) % 16;
            if (w < 0 && req[i] && i != held) w = i;
        end
        return w;
    endfunction

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                exp_gnt = -1;
                m_ptr   = 0;
                foreach (m_cnt[i]) m_cnt[i] = 0;
            end else if (port_stall) begin
                exp_gnt = -1;
            end else begin
                int w;
                w = model_pick(fu_req, exp_gnt, m_ptr, m_cnt);
                for (int i = 0; i < 16; i++) begin
                    if (i == w || !fu_req[i]) m_cnt[i] = 0;
                    else if (m_cnt[i] < STARVE_LIMIT) m_cnt[i]++;
                end
                if (w >= 0) m_ptr = (w + 1) % 16;
                exp_gnt = w;
            end
        end
    end

    // Compare DUT outputs to the model on every falling edge.
    initial begin
        forever begin
            @(negedge clk);
            check("model_sel", 32'(rfa_if.rfa_select_fu),
                  (exp_gnt < 0) ? 32'h0 : (32'h1 << exp_gnt));
            check("model_vld", 32'(rfa_if.grant_valid), (exp_gnt < 0) ? 32'h0 : 32'h1);
            check("model_id", 32'(rfa_if.grant_id), (exp_gnt < 0) ? 32'h0 : 32'(exp_gnt));
        end
    end

    // ---------------- directed vectors ----------------
    task automatic nxt(input string name, input logic [15:0] e_sel, input logic [3:0] e_id);
        @(posedge clk);
        @(negedge clk);
        check({name, "_sel"}, 32'(rfa_if.rfa_select_fu), 32'(e_sel));
        check({name, "_id"},  32'(rfa_if.grant_id),      32'(e_id));
        check({name, "_vld"}, 32'(rfa_if.grant_valid),   32'(|e_sel));
    endtask

    initial begin
        // Reset held with every FU requesting.
        fu_req = 16'hFFFF;
        repeat (3) @(negedge clk);
        check("rst_sel", 32'(rfa_if.rfa_select_fu), 32'h0);
        check("rst_vld", 32'(rfa_if.grant_valid), 32'h0);
        check("rst_id",  32'(rfa_if.grant_id), 32'h0);
        rst_n = 1'b1;

        // Full round-robin sweep 0..15 then wrap to 0.
`ifndef SGPR_RFA_STARVE_EN
        for (int k = 0; k < 17; k++) nxt("sweep", 16'h1 << (k % 16), 4'(k % 16));
`else
        repeat (17) @(negedge clk);
`endif

        // Single requester: alternates grant / idle; ptr leaves as 6.
        fu_req = 16'h0020;
        nxt("single0", 16'h0020, 4'd5);
        nxt("single1", 16'h0000, 4'd0);
        nxt("single2", 16'h0020, 4'd5);
        nxt("single3", 16'h0000, 4'd0);

        // Park the pointer at 15 via a grant to FU 14, then wrap 15 -> 0.
        fu_req = 16'h4000;
        nxt("park14", 16'h4000, 4'd14);
        fu_req = 16'h8001;
        nxt("wrap15", 16'h8000, 4'd15);
        nxt("wrap0",  16'h0001, 4'd0);
        nxt("wrap1",  16'h8000, 4'd15);

        // Stall three cycles while a grant is held; pointer (0) must not move.
        fu_req     = 16'h0030;
        port_stall = 1'b1;
        nxt("stall0", 16'h0000, 4'd0);
        nxt("stall1", 16'h0000, 4'd0);
        nxt("stall2", 16'h0000, 4'd0);
        port_stall = 1'b0;
        nxt("unstall0", 16'h0010, 4'd4);
        nxt("unstall1", 16'h0020, 4'd5);

        // Burst with ptr at 6, then asynchronous reset between edges.
        fu_req = 16'h00FF;
        nxt("burst0", 16'h0040, 4'd6);
        nxt("burst1", 16'h0080, 4'd7);
        nxt("burst2", 16'h0001, 4'd0);
        #2 rst_n = 1'b0;
        #1;
        check("arst_sel", 32'(rfa_if.rfa_select_fu), 32'h0);
        check("arst_vld", 32'(rfa_if.grant_valid), 32'h0);
        check("arst_id",  32'(rfa_if.grant_id), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        nxt("post_rst0", 16'h0001, 4'd0);
        nxt("post_rst1", 16'h0002, 4'd1);

`ifdef SGPR_RFA_STARVE_EN
        // FU 4 joins a saturated field; it must be escalated within a bounded wait.
        begin
            int waited;
            bit got;
            fu_req = 16'hFFEF;
            repeat (20) @(negedge clk);
            fu_req = 16'hFFFF;
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 16) begin
                @(negedge clk);
                waited++;
                if (rfa_if.rfa_select_fu[4]) got = 1'b1;
            end
            check("starve_fu4_granted", 32'(got), 32'h1);
        end
`endif

        fu_req = '0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    // Watchdog.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
